// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and constants for the MIPS memory responder slice.
//   MMIO_ADDR  : full byte address of the memory-mapped output register
//                (used only when MIPS_MEM_MMIO_EN is defined).
//   widx_t     : word index wide enough for any ADDR_WIDTH up to 30.
//   wb_entry_t : one write-buffer entry {word index, data}.
//   word_idx() : byte address -> word index, masked to ADDR_WIDTH bits so
//                that upper address bits alias.
// -----------------------------------------------------------------------------
package mips_mem_pkg;

  localparam logic [31:0] MMIO_ADDR = 32'hFFFF_0000;
  localparam int          WIDX_MAX  = 30;

  typedef logic [WIDX_MAX-1:0] widx_t;

  typedef struct packed {
    widx_t       idx;
    logic [31:0] data;
  } wb_entry_t;

  // Bits [1:0] are the byte offset and bits above ADDR_WIDTH+1 alias, so
  // both are dropped. A shift of WIDX_MAX wraps the mask to all ones.
  function automatic widx_t word_idx(input logic [31:0] addr, input int unsigned aw);
    widx_t mask;
    mask = (widx_t'(1) << aw) - widx_t'(1);
    return addr[31:2] & mask;
  endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// -----------------------------------------------------------------------------
// mips_mem_responder_if
// Bus bundle between the CPU/loader side (master) and the memory responder
// (slave).
//   mem_raddr/mem_dout            : CPU read address / combinational data
//   mem_waddr/mem_din/mem_wren    : CPU write, one word per cycle
//   ld_valid/ld_ready/ld_addr/ld_data : back-door loader write handshake
//   wb_count                      : registered write-buffer occupancy
//   mmio_data/mmio_valid          : MMIO output, only with MIPS_MEM_MMIO_EN
// -----------------------------------------------------------------------------
interface mips_mem_responder_if #(
  parameter  int WB_DEPTH = 4,
  localparam int CNT_W    = $clog2(WB_DEPTH) + 1
);

  logic [31:0]      mem_raddr;
  logic [31:0]      mem_dout;
  logic [31:0]      mem_waddr;
  logic [31:0]      mem_din;
  logic             mem_wren;
  logic             ld_valid;
  logic             ld_ready;
  logic [31:0]      ld_addr;
  logic [31:0]      ld_data;
  logic [CNT_W-1:0] wb_count;
`ifdef MIPS_MEM_MMIO_EN
  logic [31:0]      mmio_data;
  logic             mmio_valid;
`endif

  modport slave (
    input  mem_raddr, mem_waddr, mem_din, mem_wren,
    input  ld_valid, ld_addr, ld_data,
    output mem_dout, ld_ready, wb_count
`ifdef MIPS_MEM_MMIO_EN
    , output mmio_data, mmio_valid
`endif
  );

  modport master (
    output mem_raddr, mem_waddr, mem_din, mem_wren,
    output ld_valid, ld_addr, ld_data,
    input  mem_dout, ld_ready, wb_count
`ifdef MIPS_MEM_MMIO_EN
    , input mmio_data, mmio_valid
`endif
  );

endinterface

// File: rtl/mips_wbuf.sv
// -----------------------------------------------------------------------------
// mips_wbuf
// Circular write buffer of {word index, data} with youngest-match forwarding.
//   clk, rst          : clock, asynchronous active-low reset
//   push_i/push_entry_i : enqueue at the tail
//   pop_i             : dequeue the head (ignored when empty)
//   head_o            : oldest entry, valid while !empty_o
//   empty_o, count_o  : occupancy (registered)
//   lookup_idx_i      : word index being read by the CPU
//   hit_o/hit_data_o  : youngest pending entry matching lookup_idx_i
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module mips_wbuf
  import mips_mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  input  widx_t            lookup_idx_i,
  output logic             hit_o,
  output logic [31:0]      hit_data_o
);

  wb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] head_q,  head_d;
  logic [PTR_W-1:0] tail_q,  tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;
  logic [PTR_W-1:0] slot;

  // A push while full is only legal alongside a pop; the top level keeps
  // the loader off the port when full so that pop is always present.
  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);

  // NOTE: every variable gets its default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_pop)  head_d = head_q + PTR_W'(1);
    if (do_push) tail_d = tail_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage has no reset; stale slots are never observed
  // because count_q qualifies every read.
  always_ff @(posedge clk) begin
    if (do_push) entries_q[tail_q] <= push_entry_i;
  end

  // Walk from oldest to youngest so the last match wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    slot       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (entries_q[slot].idx == lookup_idx_i)) begin
        hit_o      = 1'b1;
        hit_data_o = entries_q[slot].data;
      end
    end
  end

  assign head_o  = entries_q[head_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mips_mem_responder.sv
// -----------------------------------------------------------------------------
// mips_mem_responder
// Responder end of the multicycle MIPS unified code/data memory.
//   clk  : clock, all state updates on posedge
//   rst  : asynchronous active-low reset
//   bus  : mips_mem_responder_if.slave (CPU read/write, loader, wb_count,
//          and mmio_data/mmio_valid when MIPS_MEM_MMIO_EN is defined)
// Optional feature macro: MIPS_MEM_MMIO_EN -- CPU writes to 32'hFFFF_0000
// bypass the buffer and load a one-word MMIO output register.
// The single array write port is shared: a loader write takes priority,
// otherwise the write-buffer head drains. The loader is refused while the
// buffer is full, which forces a drain and lets a CPU push always succeed.
// -----------------------------------------------------------------------------
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int WB_DEPTH   = 4
) (
  input logic                  clk,
  input logic                  rst,
  mips_mem_responder_if.slave  bus
);

  localparam int CNT_W = $clog2(WB_DEPTH) + 1;

  logic [31:0]      mem_q [2**ADDR_WIDTH];
  widx_t            ridx, widx, lidx;
  wb_entry_t        push_entry, head;
  logic             push, pop, empty;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic [CNT_W-1:0] count;
  logic             ld_ready, ld_fire;
  logic [31:0]      rd_data;

  assign ridx = word_idx(bus.mem_raddr, ADDR_WIDTH);
  assign widx = word_idx(bus.mem_waddr, ADDR_WIDTH);
  assign lidx = word_idx(bus.ld_addr,   ADDR_WIDTH);

  assign ld_ready = (count != CNT_W'(WB_DEPTH));
  assign ld_fire  = bus.ld_valid & ld_ready;
  assign pop      = ~ld_fire & ~empty;

  assign push_entry.idx  = widx;
  assign push_entry.data = bus.mem_din;

`ifdef MIPS_MEM_MMIO_EN
  logic        mmio_wr;
  logic [31:0] mmio_data_q, mmio_data_d;
  logic        mmio_valid_q, mmio_valid_d;

  // Full 32-bit compare: the MMIO word does not alias.
  assign mmio_wr = bus.mem_wren & (bus.mem_waddr == MMIO_ADDR);
  assign push    = bus.mem_wren & ~mmio_wr;

  always_comb begin
    mmio_valid_d = mmio_wr;
    mmio_data_d  = mmio_wr ? bus.mem_din : mmio_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mmio_data_q  <= '0;
      mmio_valid_q <= 1'b0;
    end else begin
      mmio_data_q  <= mmio_data_d;
      mmio_valid_q <= mmio_valid_d;
    end
  end

  assign bus.mmio_data  = mmio_data_q;
  assign bus.mmio_valid = mmio_valid_q;
`else
  assign push = bus.mem_wren;
`endif

  mips_wbuf #(
    .DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .empty_o      (empty),
    .count_o      (count),
    .lookup_idx_i (ridx),
    .hit_o        (fwd_hit),
    .hit_data_o   (fwd_data)
  );

  // Single write port: loader first, otherwise retire the oldest CPU write.
  // A later drain of a pending CPU entry overwrites a loader write to the
  // same word, so CPU program order wins.
  always_ff @(posedge clk) begin
    if (ld_fire)  mem_q[lidx[ADDR_WIDTH-1:0]] <= bus.ld_data;
    else if (pop) mem_q[head.idx[ADDR_WIDTH-1:0]] <= head.data;
  end

  // Pending writes are newer than the array, so forwarded data wins.
  // A push in this same cycle is not yet in the buffer, giving the
  // pre-write value as required.
  always_comb begin
    rd_data = fwd_hit ? fwd_data : mem_q[ridx[ADDR_WIDTH-1:0]];
`ifdef MIPS_MEM_MMIO_EN
    if (bus.mem_raddr == MMIO_ADDR) rd_data = mmio_data_q;
`endif
  end

  assign bus.mem_dout = rd_data;
  assign bus.ld_ready = ld_ready;
  assign bus.wb_count = count;

endmodule
